// File: rtl/itch_length_framer.sv
// itch_length_framer
//   Upstream framing stage for the speculative ITCH parser. Takes a raw byte stream of
//   length-prefixed messages (2-byte big-endian length, then payload), strips the prefix and
//   hands the payload to the length validator / payload parser. Zero-length and oversize
//   frames are dropped and flagged. All outputs are registered, one cycle after the input byte.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     in_valid/in_data input byte stream; the FSM only advances on in_valid cycles
//     flush            synchronous abort of any partial frame (beats in_valid)
//     start            1-cycle pulse, new message; expected_len valid with it
//     expected_len     payload length of the current message, held until next start
//     byte_valid/data  forwarded payload byte
//     msg_end          with the last payload byte of a message
//     oversize_err     1-cycle pulse, prefix > MAX_LEN, frame consumed silently
//     zero_len_err     1-cycle pulse, prefix == 0
//     msg_count        completed messages (wraps)
//     drop_count       oversize + zero-length frames (wraps)
module itch_length_framer #(
   parameter int MAX_LEN = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             flush,
   output logic             start,
   output logic [15:0]      expected_len,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic             msg_end,
   output logic             oversize_err,
   output logic             zero_len_err,
   output logic [CNT_W-1:0] msg_count,
   output logic [CNT_W-1:0] drop_count
);

   typedef enum logic [1:0] {LEN_HI, LEN_LO, PAYLOAD, DROP} state_t;

   localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);

   state_t      state;
   logic [7:0]  len_hi;
   logic [15:0] remaining;
   logic [15:0] len_w;

   // Full prefix, valid while in LEN_LO with the low byte on in_data.
   assign len_w = {len_hi, in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LEN_HI;
         len_hi       <= '0;
         remaining    <= '0;
         start        <= 1'b0;
         expected_len <= '0;
         byte_valid   <= 1'b0;
         byte_data    <= '0;
         msg_end      <= 1'b0;
         oversize_err <= 1'b0;
         zero_len_err <= 1'b0;
         msg_count    <= '0;
         drop_count   <= '0;
      end else begin
         // Pulses default low; level outputs (expected_len, byte_data) hold.
         start        <= 1'b0;
         byte_valid   <= 1'b0;
         msg_end      <= 1'b0;
         oversize_err <= 1'b0;
         zero_len_err <= 1'b0;
         if (flush) begin
            // Abort: byte of this cycle is discarded, nothing pulses for the lost frame.
            state     <= LEN_HI;
            remaining <= '0;
         end else if (in_valid) begin
            unique case (state)
               LEN_HI: begin
                  len_hi <= in_data;
                  state  <= LEN_LO;
               end
               LEN_LO: begin
                  if (len_w == 16'd0) begin
                     zero_len_err <= 1'b1;
                     drop_count   <= drop_count + CNT_W'(1);
                     state        <= LEN_HI;
                  end else if (len_w > MAX_LEN_L) begin
                     oversize_err <= 1'b1;
                     drop_count   <= drop_count + CNT_W'(1);
                     remaining    <= len_w;
                     state        <= DROP;
                  end else begin
                     start        <= 1'b1;
                     expected_len <= len_w;
                     remaining    <= len_w;
                     state        <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  byte_valid <= 1'b1;
                  byte_data  <= in_data;
                  remaining  <= remaining - 16'd1;
                  // remaining >= 1 here, so exiting at 1 never underflows.
                  if (remaining == 16'd1) begin
                     msg_end   <= 1'b1;
                     msg_count <= msg_count + CNT_W'(1);
                     state     <= LEN_HI;
                  end
               end
               DROP: begin
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) state <= LEN_HI;
               end
               default: state <= LEN_HI;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_itch_length_framer.sv
// Directed bench for itch_length_framer: byte-per-call stimulus, a negedge monitor that
// logs forwarded bytes/pulses, and hand-computed expectations per scenario.
module tb_itch_length_framer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        flush;
   logic        start;
   logic [15:0] expected_len;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        msg_end;
   logic        oversize_err;
   logic        zero_len_err;
   logic [15:0] msg_count;
   logic [15:0] drop_count;

   itch_length_framer #(.MAX_LEN(64), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
      .start(start), .expected_len(expected_len), .byte_valid(byte_valid),
      .byte_data(byte_data), .msg_end(msg_end), .oversize_err(oversize_err),
      .zero_len_err(zero_len_err), .msg_count(msg_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // monitor log (written only by the monitor)
   logic [7:0]  bytes[$];
   logic [15:0] lens[$];
   int n_start = 0, n_end = 0, n_ovf = 0, n_zero = 0, n_bad = 0;
   logic [7:0]  last_end_byte = '0;
   logic        in_msg = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (start) begin
            n_start++;
            lens.push_back(expected_len);
            in_msg = 1'b1;
         end
         if (byte_valid) begin
            bytes.push_back(byte_data);
            if (!in_msg || start) n_bad++;
         end
         if (msg_end) begin
            n_end++;
            last_end_byte = byte_data;
            if (!byte_valid) n_bad++;
            in_msg = 1'b0;
         end
         if (start && msg_end) n_bad++;
         if (oversize_err) n_ovf++;
         if (zero_len_err) n_zero++;
         if (oversize_err && zero_len_err) n_bad++;
      end
   end

   int n_chk = 0, n_fail = 0;
   int b_start, b_end, b_ovf, b_zero, b_bad, b_bytes, b_lens;
   logic [7:0] exq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic snap();
      b_start = n_start; b_end = n_end; b_ovf = n_ovf; b_zero = n_zero;
      b_bad = n_bad; b_bytes = bytes.size(); b_lens = lens.size();
      exq.delete();
   endtask

   task automatic ex(input logic [7:0] b);
      exq.push_back(b);
   endtask

   task automatic check_bytes(input string tag);
      check({tag, " nbytes"}, bytes.size() - b_bytes, exq.size());
      for (int i = 0; i < exq.size(); i++)
         if (b_bytes + i < bytes.size()) check({tag, " byte"}, bytes[b_bytes + i], exq[i]);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " pulses"}, {start, byte_valid, msg_end, oversize_err, zero_len_err}, 0);
      check({tag, " len"}, expected_len, 0);
      check({tag, " data"}, byte_data, 0);
      check({tag, " counts"}, {msg_count, drop_count}, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      idle(2);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // 1: single 3-byte frame
      snap();
      send(8'h00); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
      idle(2);
      ex(8'hAA); ex(8'hBB); ex(8'hCC);
      check_bytes("t1");
      check("t1 starts", n_start - b_start, 1);
      check("t1 len", lens[b_lens], 3);
      check("t1 ends", n_end - b_end, 1);
      check("t1 end byte", last_end_byte, 8'hCC);
      check("t1 msg_count", msg_count, 1);

      // 2: back-to-back frames
      do_reset(); snap();
      send(8'h00); send(8'h01); send(8'h11);
      send(8'h00); send(8'h02); send(8'h22); send(8'h33);
      idle(2);
      ex(8'h11); ex(8'h22); ex(8'h33);
      check_bytes("t2");
      check("t2 starts", n_start - b_start, 2);
      check("t2 len0", lens[b_lens], 1);
      check("t2 len1", lens[b_lens + 1], 2);
      check("t2 ends", n_end - b_end, 2);
      check("t2 msg_count", msg_count, 2);

      // 3: oversize 65 dropped, then a normal frame
      do_reset(); snap();
      send(8'h00); send(8'h41);
      for (int i = 0; i < 65; i++) send(8'(i + 1));
      send(8'h00); send(8'h01); send(8'h5A);
      idle(2);
      ex(8'h5A);
      check_bytes("t3");
      check("t3 ovf", n_ovf - b_ovf, 1);
      check("t3 drop_count", drop_count, 1);
      check("t3 msg_count", msg_count, 1);
      check("t3 starts", n_start - b_start, 1);
      check("t3 end byte", last_end_byte, 8'h5A);

      // boundary: length exactly MAX_LEN is accepted
      do_reset(); snap();
      send(8'h00); send(8'h40);
      for (int i = 0; i < 64; i++) begin send(8'(8'hC0 ^ i)); ex(8'(8'hC0 ^ i)); end
      idle(2);
      check_bytes("max");
      check("max len", lens[b_lens], 64);
      check("max ovf", n_ovf - b_ovf, 0);
      check("max msg_count", msg_count, 1);
      check("max drop_count", drop_count, 0);

      // 4: zero-length prefix skipped
      do_reset(); snap();
      send(8'h00); send(8'h00);
      send(8'h00); send(8'h01); send(8'h77);
      idle(2);
      ex(8'h77);
      check_bytes("t4");
      check("t4 zero", n_zero - b_zero, 1);
      check("t4 drop_count", drop_count, 1);
      check("t4 len", lens[b_lens], 1);
      check("t4 end byte", last_end_byte, 8'h77);
      check("t4 msg_count", msg_count, 1);

      // 5: flush mid-payload; flush beats in_valid in the same cycle
      do_reset(); snap();
      send(8'h00); send(8'h04); send(8'h01); send(8'h02);
      flush = 1'b1; send(8'hEE); flush = 1'b0;
      send(8'h00); send(8'h01); send(8'h99);
      idle(2);
      ex(8'h01); ex(8'h02); ex(8'h99);
      check_bytes("t5");
      check("t5 ends", n_end - b_end, 1);
      check("t5 msg_count", msg_count, 1);
      check("t5 starts", n_start - b_start, 2);
      check("t5 drops", drop_count, 0);

      // 6: 50-byte frame with random gaps, then reset mid-payload
      do_reset(); snap();
      send(8'h00); idle(3); send(8'h32);
      for (int i = 0; i < 50; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
         send(8'(i * 3 + 7));
         ex(8'(i * 3 + 7));
      end
      idle(2);
      check_bytes("t6");
      check("t6 len", lens[b_lens], 50);
      check("t6 msg_count", msg_count, 1);
      send(8'h00); send(8'h0A); send(8'h01); send(8'h02); send(8'h03);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t6 rst");
      idle(2);
      rst_n = 1'b1;
      idle(1);
      snap();
      send(8'h00); send(8'h02); send(8'hC1); send(8'hC2);
      idle(2);
      ex(8'hC1); ex(8'hC2);
      check_bytes("t6 post");
      check("t6 post len", lens[b_lens], 2);
      check("t6 post msg_count", msg_count, 1);
      check("t6 post end byte", last_end_byte, 8'hC2);

      check("protocol violations", n_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
